// File: rtl/shift_pkg.sv
// Shared types for the multi-pass shift sequencer: shift-unit op codes and sequencer states.
package shift_pkg;

    typedef enum logic [2:0] {
        OpTransfer = 3'b000,
        OpShl      = 3'b001,
        OpShr      = 3'b010,
        OpZero     = 3'b011,
        OpRol      = 3'b100,
        OpRor      = 3'b101,
        OpAsl      = 3'b110,
        OpAsr      = 3'b111
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_t;

    // Transfer and zero ignore the distance, so they always take exactly one pass.
    function automatic logic is_single_pass(shift_op_t op);
        return (op == OpTransfer) || (op == OpZero);
    endfunction

endpackage

// File: rtl/secuenciador_corrimiento.sv
// Multi-pass controller for an external combinational shift unit: splits a shift distance into
// passes of at most DMAX bits, feeds each result back, and returns the final word.
module secuenciador_corrimiento
    import shift_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DW    = (N - 1) / 2 + 1,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AMT_W-1:0] cmd_amount,
    input  logic [N-1:0]     cmd_data,
    input  logic             abort,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_data,
    output logic             busy,
    output logic [N-1:0]     su_F,
    output logic [2:0]       su_H,
    output logic [DW-1:0]    su_D,
    input  logic [N-1:0]     su_s
);

    localparam int unsigned DMAX = (1 << DW) - 1;

    seq_state_t       state_q, state_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    shift_op_t        op_q, op_d;

    logic [DW-1:0]    pass_amt;
    logic [AMT_W-1:0] rem_after;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            op_q    <= OpTransfer;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    // Distance for the current pass: min(rem, DMAX), forced to 0 for distance-free ops.
    always_comb begin
        pass_amt = '0;
        if (!is_single_pass(op_q)) begin
            if (32'(rem_q) > DMAX) begin
                pass_amt = DW'(DMAX);
            end else begin
                pass_amt = DW'(rem_q);
            end
        end
        rem_after = rem_q - AMT_W'(pass_amt);
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        op_d      = op_q;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        busy      = (state_q != IDLE);
        su_F      = acc_q;
        su_H      = 3'b000;
        su_D      = '0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    acc_d = cmd_data;
                    op_d  = shift_op_t'(cmd_op);
                    rem_d = cmd_amount;
                    if (is_single_pass(shift_op_t'(cmd_op))) begin
                        state_d = RUN;
                    end else if (cmd_amount == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                su_H = op_q;
                su_D = pass_amt;
                if (abort) begin
                    // Cancelled: drop this pass, keep the accumulator as it was.
                    state_d = IDLE;
                end else begin
                    acc_d = su_s;
                    rem_d = rem_after;
                    if (is_single_pass(op_q) || (rem_after == '0)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                res_valid = 1'b1;
                res_data  = acc_q;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
